cfg_ram_loader: RTL and testbench

- Write-side master for the per-stage config SRAM banks.
- Accepts a valid/ready stream of 64-bit load packets from the host/config bus: one header word, then N payload words.
- Drives the banks' shared write port (sram_sel, wr_addr, wr_en, din) one write per accepted payload word.
- Auto-increments the address and rolls into the next SRAM, then reports done or error status.

---
 rtl/cfg_ram_loader_pkg.sv | 50 +++++
 rtl/cfg_ram_loader_if.sv | 27 ++
 rtl/cfg_ram_loader_wr_ptr.sv | 51 +++++
 rtl/cfg_ram_loader.sv | 145 ++++++++++++++
 tb/tb_cfg_ram_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_ram_loader_pkg.sv
// Shared definitions for the config RAM loader: geometry, header layout,
// error-code bits and the loader FSM encoding.
package cfg_ram_loader_pkg;

    localparam int NUM_SRAM   = 8;
    localparam int CFG_DEPTH  = 4;
    localparam int ADDR_WIDTH = 2;
    localparam int DATA_WIDTH = 64;
    localparam int CNT_WIDTH  = 10;
    localparam int SEL_WIDTH  = 8;

    localparam logic [7:0] MAGIC = 8'hC5;

    // Header word layout
    localparam int HDR_SEL_LSB  = 0;
    localparam int HDR_ADDR_LSB = 8;
    localparam int HDR_CNT_LSB  = 16;
    localparam int HDR_TAG_LSB  = 56;

    // err_code bit positions and the matching one-hot masks
    localparam int ERR_BAD_HDR = 0;
    localparam int ERR_SHORT   = 1;
    localparam int ERR_RANGE   = 2;
    localparam logic [2:0] ERR_BAD_HDR_M = 3'(1 << ERR_BAD_HDR);
    localparam logic [2:0] ERR_SHORT_M   = 3'(1 << ERR_SHORT);
    localparam logic [2:0] ERR_RANGE_M   = 3'(1 << ERR_RANGE);

    // Sized forms of the geometry limits for width-clean compares
    localparam logic [SEL_WIDTH-1:0]  NUM_SRAM_S = SEL_WIDTH'(NUM_SRAM);
    localparam logic [ADDR_WIDTH:0]   DEPTH_S    = (ADDR_WIDTH+1)'(CFG_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CFG_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // A header is unusable if its tag is wrong, it carries no payload,
    // or its start pointer lies outside the bank array.
    function automatic logic hdr_bad(input logic [7:0]            tag,
                                     input logic [CNT_WIDTH-1:0]  cnt,
                                     input logic [SEL_WIDTH-1:0]  sel,
                                     input logic [ADDR_WIDTH-1:0] addr);
        return (tag != MAGIC) || (cnt == '0) || (sel >= NUM_SRAM_S) ||
               ({1'b0, addr} >= DEPTH_S);
    endfunction

endpackage

// File: rtl/cfg_ram_loader_if.sv
// Load stream in, shared bank write port out.
// Stream handshake: a word transfers on a rising clk edge where s_valid and
// s_ready are both high; the source holds s_data/s_last stable while s_valid
// is high and s_ready is low, and s_ready never depends on s_valid.
interface cfg_ram_loader_if;
    import cfg_ram_loader_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;

    logic [SEL_WIDTH-1:0]  sram_sel;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;

    modport master (
        input  s_valid, s_data, s_last,
        output s_ready, sram_sel, wr_addr, wr_en, din
    );

    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready, sram_sel, wr_addr, wr_en, din
    );
endinterface

// File: rtl/cfg_ram_loader_wr_ptr.sv
// Bank/entry write pointer: loads from the header, steps through entries and
// rolls into the next bank; stops moving once it has left the bank array.
module cfg_wr_ptr
    import cfg_ram_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [SEL_WIDTH-1:0]  sel_ld_i,
    input  logic [ADDR_WIDTH-1:0] addr_ld_i,
    input  logic                  adv_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  oor_o
);
    logic [SEL_WIDTH-1:0]  sel_q,  sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign oor_o = (sel_q >= NUM_SRAM_S);

    // Next pointer: load wins, advance only while still in range
    always_comb begin
        sel_d  = sel_q;
        addr_d = addr_q;
        if (load_i) begin
            sel_d  = sel_ld_i;
            addr_d = addr_ld_i;
        end else if (adv_i && !oor_o) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
                sel_d  = sel_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Pointer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= '0;
            addr_q <= '0;
        end else begin
            sel_q  <= sel_d;
            addr_q <= addr_d;
        end
    end

    assign sel_o  = sel_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/cfg_ram_loader.sv
// Config RAM loader: parses a header word, then turns each payload word into
// one registered write on the shared bank write port, with status reporting.
module cfg_ram_loader
    import cfg_ram_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cfg_ram_loader_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [CNT_WIDTH-1:0] wr_count,
    output state_t               state_o
);
    state_t                state_q;
    logic                  s_ready_q, wr_en_q, busy_q, done_q, err_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [2:0]            err_code_q, err_data_d;
    logic [CNT_WIDTH-1:0]  wr_count_q, remain_q;

    logic                  hs, hdr_is_bad, last_word;
    logic [SEL_WIDTH-1:0]  ptr_sel;
    logic [ADDR_WIDTH-1:0] ptr_addr;
    logic                  ptr_oor;

    assign hs        = bus.s_valid & s_ready_q;
    assign last_word = (remain_q == CNT_WIDTH'(1));
    assign hdr_is_bad = hdr_bad(bus.s_data[HDR_TAG_LSB  +: 8],
                                bus.s_data[HDR_CNT_LSB  +: CNT_WIDTH],
                                bus.s_data[HDR_SEL_LSB  +: SEL_WIDTH],
                                bus.s_data[HDR_ADDR_LSB +: ADDR_WIDTH]);

    cfg_wr_ptr u_ptr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (hs && (state_q == ST_IDLE)),
        .sel_ld_i  (bus.s_data[HDR_SEL_LSB  +: SEL_WIDTH]),
        .addr_ld_i (bus.s_data[HDR_ADDR_LSB +: ADDR_WIDTH]),
        .adv_i     (hs && (state_q == ST_DATA)),
        .sel_o     (ptr_sel),
        .addr_o    (ptr_addr),
        .oor_o     (ptr_oor)
    );

    // Error bits picked up by a payload word: suppressed write, early s_last,
    // or count exhausted before s_last
    always_comb begin
        err_data_d = err_code_q;
        if (ptr_oor)                     err_data_d = err_data_d | ERR_RANGE_M;
        if (bus.s_last && !last_word)    err_data_d = err_data_d | ERR_SHORT_M;
        if (!bus.s_last && last_word)    err_data_d = err_data_d | ERR_RANGE_M;
    end

    // Loader FSM with registered stream-ready, write port and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            err_code_q <= '0;
            wr_count_q <= '0;
            remain_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (hs) begin
                        busy_q     <= 1'b1;
                        wr_count_q <= '0;
                        remain_q   <= bus.s_data[HDR_CNT_LSB +: CNT_WIDTH];
                        if (hdr_is_bad) begin
                            err_code_q <= ERR_BAD_HDR_M;
                            state_q    <= bus.s_last ? ST_FIN : ST_DRAIN;
                            s_ready_q  <= !bus.s_last;
                        end else if (bus.s_last) begin
                            err_code_q <= ERR_SHORT_M;
                            state_q    <= ST_FIN;
                            s_ready_q  <= 1'b0;
                        end else begin
                            err_code_q <= '0;
                            state_q    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        remain_q   <= remain_q - 1'b1;
                        err_code_q <= err_data_d;
                        if (!ptr_oor) begin
                            wr_en_q    <= 1'b1;
                            sel_q      <= ptr_sel;
                            addr_q     <= ptr_addr;
                            din_q      <= bus.s_data;
                            wr_count_q <= wr_count_q + 1'b1;
                        end
                        if (bus.s_last) begin
                            state_q   <= ST_FIN;
                            s_ready_q <= 1'b0;
                        end else if (last_word) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (hs && bus.s_last) begin
                        state_q   <= ST_FIN;
                        s_ready_q <= 1'b0;
                    end
                end
                ST_FIN: begin
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= (err_code_q == '0);
                    err_q     <= (err_code_q != '0);
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.sram_sel = sel_q;
    assign bus.wr_addr  = addr_q;
    assign bus.din      = din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign wr_count     = wr_count_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_cfg_ram_loader.sv
// Directed bench for cfg_ram_loader: packet scenarios with hand-computed
// write sequences and status values.
module tb_cfg_ram_loader;
    import cfg_ram_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done, err;
    logic [2:0] err_code;
    logic [CNT_WIDTH-1:0] wr_count;
    state_t state_o;

    cfg_ram_loader_if bus();

    cfg_ram_loader dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .wr_count (wr_count),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0]  sel;
        logic [1:0]  addr;
        logic [63:0] din;
    } wr_t;

    wr_t wq[$];
    int  done_n = 0, err_n = 0;
    int  last_wr_cyc = 0, done_cyc = 0;
    int  w0, d0, e0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the write port and status pulses away from the clock edge
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wq.push_back('{sel: bus.sram_sel, addr: bus.wr_addr, din: bus.din});
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err) err_n++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] tag, input logic [9:0] n,
                                        input logic [7:0] sel, input logic [1:0] addr);
        return {tag, 30'b0, n, 6'b0, addr, sel};
    endfunction

    task automatic mark();
        w0 = wq.size();
        d0 = done_n;
        e0 = err_n;
    endtask

    // Present one word, wait for acceptance, optionally idle a cycle after
    task automatic send(input logic [63:0] d, input logic l, input bit gap);
        int t;
        logic seen;
        t = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        seen = bus.s_ready;
        chk("s_ready_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [7:0] s,
                          input logic [1:0] a, input logic [63:0] d);
        if (w0 + k < wq.size()) begin
            chk({tag, "_sel"},  64'(wq[w0+k].sel),  64'(s));
            chk({tag, "_addr"}, 64'(wq[w0+k].addr), 64'(a));
            chk({tag, "_din"},  wq[w0+k].din,       d);
        end
    endtask

    task automatic chk_status(input string tag, input int nwr, input int nd, input int ne,
                              input logic [2:0] code, input int cnt);
        chk({tag, "_nwr"},   64'(wq.size() - w0), 64'(nwr));
        chk({tag, "_done"},  64'(done_n - d0),    64'(nd));
        chk({tag, "_err"},   64'(err_n - e0),     64'(ne));
        chk({tag, "_code"},  64'(err_code),       64'(code));
        chk({tag, "_count"}, 64'(wr_count),       64'(cnt));
        chk({tag, "_busy"},  64'(busy),           64'd0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_busy",  64'(busy),        64'd0);
        chk("rst_wren",  64'(bus.wr_en),   64'd0);
        chk("rst_code",  64'(err_code),    64'd0);
        chk("rst_count", 64'(wr_count),    64'd0);
        chk("rst_state", 64'(state_o),     64'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: N=3 at (2,1), clean finish
        mark();
        send(hdr(8'hC5, 10'd3, 8'd2, 2'd1), 1'b0, 1'b0);
        chk("t1_busy_hdr", 64'(busy), 64'd1);
        send(64'h1111_0000_0000_0001, 1'b0, 1'b0);
        send(64'h1111_0000_0000_0002, 1'b0, 1'b0);
        send(64'h1111_0000_0000_0003, 1'b1, 1'b0);
        settle();
        chk_status("t1", 3, 1, 0, 3'b000, 3);
        chk_wr("t1_w0", 0, 8'd2, 2'd1, 64'h1111_0000_0000_0001);
        chk_wr("t1_w1", 1, 8'd2, 2'd2, 64'h1111_0000_0000_0002);
        chk_wr("t1_w2", 2, 8'd2, 2'd3, 64'h1111_0000_0000_0003);
        chk("t1_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);

        // 2: address wrap into next bank
        mark();
        send(hdr(8'hC5, 10'd2, 8'd0, 2'd3), 1'b0, 1'b0);
        send(64'h2222_0000_0000_00AA, 1'b0, 1'b0);
        send(64'h2222_0000_0000_00BB, 1'b1, 1'b0);
        settle();
        chk_status("t2", 2, 1, 0, 3'b000, 2);
        chk_wr("t2_w0", 0, 8'd0, 2'd3, 64'h2222_0000_0000_00AA);
        chk_wr("t2_w1", 1, 8'd1, 2'd0, 64'h2222_0000_0000_00BB);

        // 3: run off the last bank
        mark();
        send(hdr(8'hC5, 10'd3, 8'd7, 2'd3), 1'b0, 1'b0);
        send(64'h3333_0000_0000_0001, 1'b0, 1'b0);
        send(64'h3333_0000_0000_0002, 1'b0, 1'b0);
        send(64'h3333_0000_0000_0003, 1'b1, 1'b0);
        settle();
        chk_status("t3", 1, 0, 1, 3'b100, 1);
        chk_wr("t3_w0", 0, 8'd7, 2'd3, 64'h3333_0000_0000_0001);

        // 4: bad tag, four words drained
        mark();
        send(hdr(8'hA0, 10'd4, 8'd0, 2'd0), 1'b0, 1'b0);
        send(64'h4444_0000_0000_0001, 1'b0, 1'b0);
        send(64'h4444_0000_0000_0002, 1'b0, 1'b0);
        chk("t4_drain_ready", 64'(bus.s_ready), 64'd1);
        chk("t4_drain_busy",  64'(busy),        64'd1);
        chk("t4_drain_state", 64'(state_o),     64'(ST_DRAIN));
        send(64'h4444_0000_0000_0003, 1'b0, 1'b0);
        send(64'h4444_0000_0000_0004, 1'b1, 1'b0);
        settle();
        chk_status("t4", 0, 0, 1, 3'b001, 0);

        // 5a: short packet
        mark();
        send(hdr(8'hC5, 10'd4, 8'd1, 2'd0), 1'b0, 1'b0);
        send(64'h5555_0000_0000_0001, 1'b0, 1'b0);
        send(64'h5555_0000_0000_0002, 1'b1, 1'b0);
        settle();
        chk_status("t5a", 2, 0, 1, 3'b010, 2);
        chk_wr("t5a_w1", 1, 8'd1, 2'd1, 64'h5555_0000_0000_0002);

        // 5b: long packet
        mark();
        send(hdr(8'hC5, 10'd1, 8'd3, 2'd2), 1'b0, 1'b0);
        send(64'h5B5B_0000_0000_0001, 1'b0, 1'b0);
        send(64'h5B5B_0000_0000_0002, 1'b0, 1'b0);
        send(64'h5B5B_0000_0000_0003, 1'b1, 1'b0);
        settle();
        chk_status("t5b", 1, 0, 1, 3'b100, 1);
        chk_wr("t5b_w0", 0, 8'd3, 2'd2, 64'h5B5B_0000_0000_0001);

        // 6: gapped valid
        mark();
        send(hdr(8'hC5, 10'd4, 8'd4, 2'd0), 1'b0, 1'b1);
        send(64'h6666_0000_0000_0001, 1'b0, 1'b1);
        send(64'h6666_0000_0000_0002, 1'b0, 1'b1);
        send(64'h6666_0000_0000_0003, 1'b0, 1'b1);
        send(64'h6666_0000_0000_0004, 1'b1, 1'b1);
        settle();
        chk_status("t6", 4, 1, 0, 3'b000, 4);
        chk_wr("t6_w0", 0, 8'd4, 2'd0, 64'h6666_0000_0000_0001);
        chk_wr("t6_w1", 1, 8'd4, 2'd1, 64'h6666_0000_0000_0002);
        chk_wr("t6_w2", 2, 8'd4, 2'd2, 64'h6666_0000_0000_0003);
        chk_wr("t6_w3", 3, 8'd4, 2'd3, 64'h6666_0000_0000_0004);

        // 7: async reset mid-packet, then a fresh packet
        send(hdr(8'hC5, 10'd4, 8'd5, 2'd0), 1'b0, 1'b0);
        send(64'h7777_0000_0000_0001, 1'b0, 1'b0);
        send(64'h7777_0000_0000_0002, 1'b0, 1'b0);
        chk("t7_pre_wren", 64'(bus.wr_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_wren",  64'(bus.wr_en),    64'd0);
        chk("t7_rst_busy",  64'(busy),         64'd0);
        chk("t7_rst_ready", 64'(bus.s_ready),  64'd0);
        chk("t7_rst_sel",   64'(bus.sram_sel), 64'd0);
        chk("t7_rst_count", 64'(wr_count),     64'd0);
        chk("t7_rst_state", 64'(state_o),      64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        mark();
        send(hdr(8'hC5, 10'd1, 8'd6, 2'd2), 1'b0, 1'b0);
        send(64'h7A7A_0000_0000_0001, 1'b1, 1'b0);
        settle();
        chk_status("t7", 1, 1, 0, 3'b000, 1);
        chk_wr("t7_w0", 0, 8'd6, 2'd2, 64'h7A7A_0000_0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
